// File: rtl/lfsr_rx_descrambler_if.sv
// Bus bundle for lfsr_rx_descrambler.
// Carries the register access port (write/read/addr/lfsrdin/rdata) and the
// scrambled-in / descrambled-out beat stream with lock status.
//   master : drives register strobes and scrambled beats, observes results
//   slave  : the descrambler itself
interface lfsr_rx_descrambler_if;
  logic        write;
  logic        read;
  logic [11:0] addr;
  logic [31:0] lfsrdin;
  logic [31:0] rdata;
  logic        din_valid;
  logic        din_sof;
  logic [13:0] din;
  logic        dout_valid;
  logic        dout_sof;
  logic [13:0] dout;
  logic        locked;
  logic        sync_err;

  modport master (
    output write, read, addr, lfsrdin, din_valid, din_sof, din,
    input  rdata, dout_valid, dout_sof, dout, locked, sync_err
  );

  modport slave (
    input  write, read, addr, lfsrdin, din_valid, din_sof, din,
    output rdata, dout_valid, dout_sof, dout, locked, sync_err
  );
endinterface

// File: rtl/lfsr_rx_descrambler.sv
// lfsr_rx_descrambler
// Receive-side descrambler for the 86-bit primary scrambler LFSR. A local LFSR
// is seeded over the register bus, advanced 14 steps per consumed beat, and its
// keystream is XORed onto the incoming word. A frame-sync FSM compares the
// descrambled SOF beat of each frame against SYNC_WORD and reports lock.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset
//   bus  - lfsr_rx_descrambler_if.slave: register port (write, read, addr,
//          lfsrdin, rdata) and beat stream (din_valid, din_sof, din ->
//          dout_valid, dout_sof, dout, locked, sync_err)
// Registers:
//   0x0e4 seed[31:0], 0x0e5 seed[63:32], 0x0e6 seed[85:64] (write loads LFSR,
//   enters HUNT), 0x0e7 status {28'b0, wr_drop, state[1:0], locked},
//   0x0e8 sync error counter (only with RX_ERR_CNT_EN defined, else reads 0).
// Build option: define RX_ERR_CNT_EN to include the 16-bit saturating
// sync_err counter.
//
// FSM states
//   state  | meaning
//   IDLE   | no seed loaded, beats dropped, LFSR held
//   HUNT   | descrambling, counting consecutive good SOF beats
//   LOCKED | frame sync acquired, counting consecutive bad SOF beats
module lfsr_rx_descrambler #(
  parameter int                        POLY_WIDTH   = 86,
  parameter int                        NUM_OF_STEPS = 14,
  parameter logic [NUM_OF_STEPS-1:0]   SYNC_WORD    = 14'h2A5C,
  parameter int                        LOCK_CNT     = 3,
  parameter int                        UNLOCK_CNT   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  lfsr_rx_descrambler_if.slave bus
);

  localparam logic [11:0] ADDR_SEED0  = 12'h0e4;
  localparam logic [11:0] ADDR_SEED1  = 12'h0e5;
  localparam logic [11:0] ADDR_SEED2  = 12'h0e6;
  localparam logic [11:0] ADDR_STATUS = 12'h0e7;
  localparam logic [11:0] ADDR_ERRCNT = 12'h0e8;

  localparam logic [2:0] LOCK_TC   = 3'(LOCK_CNT);
  localparam logic [2:0] UNLOCK_TC = 3'(UNLOCK_CNT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HUNT   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic [2:0] good_cnt, good_cnt_nxt;
  logic [2:0] bad_cnt, bad_cnt_nxt;

  logic [POLY_WIDTH-1:0]   lfsr;
  logic [POLY_WIDTH-1:0]   ks_s;
  logic [POLY_WIDTH-1:0]   lfsr_next_beat;
  logic [NUM_OF_STEPS-1:0] ks;
  logic [NUM_OF_STEPS-1:0] descr;

  logic [31:0] seed_lo;
  logic [31:0] seed_mid;
  logic [21:0] seed_hi;
  logic        wr_drop;
  logic        locked;
  logic [31:0] rd_mux;

  logic consume, seed_hit, wr_blocked, load;
  logic sof_good, sof_bad;

  // One LFSR step: rotate left, feedback bit also XORed into the tap positions.
  function automatic logic [POLY_WIDTH-1:0] lfsr_step(input logic [POLY_WIDTH-1:0] s);
    logic [POLY_WIDTH-1:0] n;
    n     = {s[POLY_WIDTH-2:0], s[POLY_WIDTH-1]};
    n[32] = n[32] ^ s[POLY_WIDTH-1];
    n[47] = n[47] ^ s[POLY_WIDTH-1];
    n[56] = n[56] ^ s[POLY_WIDTH-1];
    n[65] = n[65] ^ s[POLY_WIDTH-1];
    n[78] = n[78] ^ s[POLY_WIDTH-1];
    return n;
  endfunction

  // Keystream bit j is the MSB before the j-th step of this beat.
  always_comb begin
    ks   = '0;
    ks_s = lfsr;
    for (int j = 0; j < NUM_OF_STEPS; j++) begin
      ks[j] = ks_s[POLY_WIDTH-1];
      ks_s  = lfsr_step(ks_s);
    end
    lfsr_next_beat = ks_s;
  end

  assign descr = bus.din ^ ks;

  assign consume    = bus.din_valid && (state != IDLE);
  assign seed_hit   = bus.write && (bus.addr inside {ADDR_SEED0, ADDR_SEED1, ADDR_SEED2});
  // A seed write colliding with a consumed beat would corrupt the running
  // keystream mid-frame, so the beat wins and the write is dropped.
  assign wr_blocked = seed_hit && consume;
  assign load       = bus.write && (bus.addr == ADDR_SEED2) && !consume;
  assign sof_good   = consume && bus.din_sof && (descr == SYNC_WORD);
  assign sof_bad    = consume && bus.din_sof && (descr != SYNC_WORD);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      good_cnt <= '0;
      bad_cnt  <= '0;
    end else begin
      state    <= state_nxt;
      good_cnt <= good_cnt_nxt;
      bad_cnt  <= bad_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    good_cnt_nxt = good_cnt;
    bad_cnt_nxt  = bad_cnt;
    if (load) begin
      state_nxt    = HUNT;
      good_cnt_nxt = '0;
      bad_cnt_nxt  = '0;
    end else begin
      case (state)
        IDLE: ;
        HUNT: begin
          if (sof_good) begin
            if (good_cnt + 3'd1 == LOCK_TC) begin
              state_nxt    = LOCKED;
              good_cnt_nxt = '0;
            end else begin
              good_cnt_nxt = good_cnt + 3'd1;
            end
          end else if (sof_bad) begin
            good_cnt_nxt = '0;
          end
        end
        LOCKED: begin
          if (sof_bad) begin
            if (bad_cnt + 3'd1 == UNLOCK_TC) begin
              state_nxt   = HUNT;
              bad_cnt_nxt = '0;
            end else begin
              bad_cnt_nxt = bad_cnt + 3'd1;
            end
          end else if (sof_good) begin
            bad_cnt_nxt = '0;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // locked follows the registered state so it lines up with dout_valid of
  // the SOF beat that caused the transition.
  assign locked = (state == LOCKED);

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr           <= '0;
      seed_lo        <= '0;
      seed_mid       <= '0;
      seed_hi        <= '0;
      wr_drop        <= 1'b0;
      bus.dout_valid <= 1'b0;
      bus.dout_sof   <= 1'b0;
      bus.dout       <= '0;
      bus.sync_err   <= 1'b0;
      bus.rdata      <= '0;
    end else begin
      if (consume) begin
        lfsr <= lfsr_next_beat;
      end else if (load) begin
        lfsr <= {bus.lfsrdin[21:0], seed_mid, seed_lo};
      end

      if (bus.write && !consume) begin
        case (bus.addr)
          ADDR_SEED0: seed_lo  <= bus.lfsrdin;
          ADDR_SEED1: seed_mid <= bus.lfsrdin;
          ADDR_SEED2: seed_hi  <= bus.lfsrdin[21:0];
          default: ;
        endcase
      end

      if (load) begin
        wr_drop <= 1'b0;
      end else if (wr_blocked) begin
        wr_drop <= 1'b1;
      end

      bus.dout_valid <= consume;
      bus.dout_sof   <= consume && bus.din_sof;
      bus.sync_err   <= sof_bad;
      if (consume) begin
        bus.dout <= descr;
      end

      if (bus.read) begin
        bus.rdata <= rd_mux;
      end
    end
  end

  assign bus.locked = locked;

`ifdef RX_ERR_CNT_EN
  logic [15:0] err_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (bus.write && (bus.addr == ADDR_ERRCNT)) begin
      err_cnt <= '0;
    end else if (sof_bad && (err_cnt != 16'hFFFF)) begin
      err_cnt <= err_cnt + 16'd1;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (bus.addr)
      ADDR_SEED0:  rd_mux = seed_lo;
      ADDR_SEED1:  rd_mux = seed_mid;
      ADDR_SEED2:  rd_mux = {10'b0, seed_hi};
      ADDR_STATUS: rd_mux = {28'b0, wr_drop, state, locked};
      ADDR_ERRCNT: rd_mux = {16'b0, err_cnt};
      default:     rd_mux = '0;
    endcase
  end
`else
  always_comb begin
    rd_mux = '0;
    case (bus.addr)
      ADDR_SEED0:  rd_mux = seed_lo;
      ADDR_SEED1:  rd_mux = seed_mid;
      ADDR_SEED2:  rd_mux = {10'b0, seed_hi};
      ADDR_STATUS: rd_mux = {28'b0, wr_drop, state, locked};
      ADDR_ERRCNT: rd_mux = '0;
      default:     rd_mux = '0;
    endcase
  end
`endif

endmodule

// File: tb/tb_lfsr_rx_descrambler.sv
module tb_lfsr_rx_descrambler;

  logic clk;
  logic rst;

  lfsr_rx_descrambler_if bus ();

  lfsr_rx_descrambler dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [85:0] obs, input logic [85:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reg_wr(input logic [11:0] a, input logic [31:0] d);
    bus.write   = 1'b1;
    bus.addr    = a;
    bus.lfsrdin = d;
    tick();
    bus.write   = 1'b0;
  endtask

  task automatic reg_rd(input logic [11:0] a, output logic [31:0] d);
    bus.read = 1'b1;
    bus.addr = a;
    tick();
    bus.read = 1'b0;
    d = bus.rdata;
  endtask

  task automatic seed(input logic [31:0] hi, input logic [31:0] mid, input logic [31:0] lo);
    reg_wr(12'h0e4, lo);
    reg_wr(12'h0e5, mid);
    reg_wr(12'h0e6, hi);
  endtask

  task automatic beat(input logic sof, input logic [13:0] d);
    bus.din_valid = 1'b1;
    bus.din_sof   = sof;
    bus.din       = d;
    tick();
    bus.din_valid = 1'b0;
    bus.din_sof   = 1'b0;
  endtask

  localparam logic [13:0] SYNC = 14'h2A5C;

  logic [31:0] rd;
  logic [85:0] exp_lfsr;
  logic [13:0] bad_dout [4];

  initial begin
    bus.write = 0; bus.read = 0; bus.addr = '0; bus.lfsrdin = '0;
    bus.din_valid = 0; bus.din_sof = 0; bus.din = '0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;

    // reset state and IDLE drop
    reg_rd(12'h0e7, rd);            chk("status_reset", rd, 32'h0);
    chk("locked_reset", bus.locked, 1'b0);
    beat(1'b1, SYNC);
    chk("idle_no_valid", bus.dout_valid, 1'b0);
    chk("idle_lfsr_held", dut.lfsr, 86'h0);
    reg_rd(12'h0e7, rd);            chk("status_idle", rd, 32'h0);

    // seed = 1: first beat has zero keystream
    seed(32'h0, 32'h0, 32'h1);
    reg_rd(12'h0e7, rd);            chk("status_hunt", rd, 32'h2);
    beat(1'b0, 14'h1234);
    chk("seed1_valid", bus.dout_valid, 1'b1);
    chk("seed1_dout", bus.dout, 14'h1234);
    chk("seed1_sof", bus.dout_sof, 1'b0);
    exp_lfsr = 86'd1 << 14;
    chk("seed1_lfsr", dut.lfsr, exp_lfsr);

    // seed = bit 85 only: ks = bits 0 and 8
    seed(32'h0020_0000, 32'h0, 32'h0);
    beat(1'b0, 14'h0101);
    chk("seed85_dout", bus.dout, 14'h0000);

    // lock with three good SOFs, then lose it with four bad ones
    seed(32'h0, 32'h0, 32'h1);
    for (int i = 0; i < 3; i++) begin
      beat(1'b1, SYNC);
      chk("lock_dout", bus.dout, SYNC);
      chk("lock_sof", bus.dout_sof, 1'b1);
      chk("lock_syncerr", bus.sync_err, 1'b0);
      chk("lock_locked", bus.locked, (i == 2) ? 1'b1 : 1'b0);
    end
    reg_rd(12'h0e7, rd);            chk("status_locked", rd, 32'h5);
    // fourth bad beat runs from lfsr = 1<<84: ks bits 1 and 9
    bad_dout[0] = 14'h0000; bad_dout[1] = 14'h0000;
    bad_dout[2] = 14'h0000; bad_dout[3] = 14'h0202;
    for (int i = 0; i < 4; i++) begin
      beat(1'b1, 14'h0000);
      chk("unlock_dout", bus.dout, bad_dout[i]);
      chk("unlock_syncerr", bus.sync_err, 1'b1);
      chk("unlock_locked", bus.locked, (i < 3) ? 1'b1 : 1'b0);
    end
    tick();
    chk("syncerr_pulse", bus.sync_err, 1'b0);
    reg_rd(12'h0e7, rd);            chk("status_unlocked", rd, 32'h2);

    // seed write colliding with a consumed beat is dropped
    bus.write = 1'b1; bus.addr = 12'h0e4; bus.lfsrdin = 32'hDEAD_BEEF;
    bus.din_valid = 1'b1; bus.din_sof = 1'b0; bus.din = 14'h0;
    tick();
    bus.write = 1'b0; bus.din_valid = 1'b0;
    chk("drop_beat_valid", bus.dout_valid, 1'b1);
    reg_rd(12'h0e4, rd);            chk("drop_seed_kept", rd, 32'h1);
    reg_rd(12'h0e7, rd);            chk("drop_status", rd, 32'hA);
    reg_wr(12'h0e6, 32'h0);
    reg_rd(12'h0e7, rd);            chk("drop_cleared", rd, 32'h2);

    // non-SOF beats leave the good counter alone
    seed(32'h0, 32'h0, 32'h1);
    beat(1'b1, SYNC); beat(1'b1, SYNC);
    beat(1'b0, 14'h0000);
    chk("nonsof_syncerr", bus.sync_err, 1'b0);
    beat(1'b1, SYNC);
    chk("nonsof_locked", bus.locked, 1'b1);

    // bad SOF in HUNT restarts the good count
    seed(32'h0, 32'h0, 32'h1);
    beat(1'b1, SYNC); beat(1'b1, SYNC);
    beat(1'b1, 14'h0000);
    chk("hunt_bad_syncerr", bus.sync_err, 1'b1);
    beat(1'b1, SYNC); beat(1'b1, SYNC);
    chk("hunt_restart_nolock", bus.locked, 1'b0);
    beat(1'b1, SYNC);
    chk("hunt_restart_lock", bus.locked, 1'b1);

    // reset while locked
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_locked", bus.locked, 1'b0);
    chk("rst_valid", bus.dout_valid, 1'b0);
    chk("rst_lfsr", dut.lfsr, 86'h0);
    reg_rd(12'h0e4, rd);            chk("rst_seed_lost", rd, 32'h0);
    reg_rd(12'h0e7, rd);            chk("rst_status", rd, 32'h0);

    // unmapped read after a nonzero read
    seed(32'h0, 32'h0, 32'h1);
    reg_rd(12'h0e4, rd);            chk("seed_readback", rd, 32'h1);
    reg_rd(12'h123, rd);            chk("unmapped_read", rd, 32'h0);

`ifdef RX_ERR_CNT_EN
    for (int i = 0; i < 5; i++) beat(1'b1, 14'h0000);
    reg_rd(12'h0e8, rd);            chk("errcnt_five", rd, 32'd5);
    reg_wr(12'h0e8, 32'h0);
    reg_rd(12'h0e8, rd);            chk("errcnt_clear", rd, 32'd0);
    // clear and a bad SOF in the same cycle: clear wins
    bus.write = 1'b1; bus.addr = 12'h0e8; bus.lfsrdin = 32'h0;
    bus.din_valid = 1'b1; bus.din_sof = 1'b1; bus.din = 14'h0;
    tick();
    bus.write = 1'b0; bus.din_valid = 1'b0; bus.din_sof = 1'b0;
    chk("errcnt_clr_syncerr", bus.sync_err, 1'b1);
    reg_rd(12'h0e8, rd);            chk("errcnt_clear_wins", rd, 32'd0);
    // far more bad SOFs than the counter can hold
    bus.din_valid = 1'b1; bus.din_sof = 1'b1; bus.din = 14'h0;
    repeat (66000) tick();
    bus.din_valid = 1'b0; bus.din_sof = 1'b0;
    reg_rd(12'h0e8, rd);            chk("errcnt_saturate", rd, 32'h0000_FFFF);
`else
    beat(1'b1, 14'h0000);
    reg_wr(12'h0e8, 32'hFFFF_FFFF);
    reg_rd(12'h0e8, rd);            chk("errcnt_absent", rd, 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
